// File: rtl/life_gen_sequencer.sv
// life_gen_sequencer
// ------------------
// Owns a WIDTH x HEIGHT Game of Life grid (B3/S23) and steps it a requested
// number of generations. One cell is evaluated per cycle, in row-major order
// (column fastest), by a single shared neighbour-count/rule evaluator. Results
// go to a shadow grid, which is copied into the committed grid at the end of
// every generation.
//
// Run timing: with start accepted at edge 0, DONE is entered at edge
// steps*(WIDTH*HEIGHT+1) (WIDTH*HEIGHT scan cycles plus one commit cycle per
// generation).
//
// Build option:
//   TOROIDAL_WRAP_EN  defined   -> neighbour coordinates wrap around the edges
//                     undefined -> cells outside the grid count as dead
//
// Handshake: i_start is a level sampled only in IDLE; it is accepted on the
// first rising edge of i_clk on which it is high while the FSM is in IDLE.
// o_done is a one-cycle pulse (the DONE state). i_row_wr_en is honoured only
// in IDLE and DONE.
//
// Ports:
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_row_wr_en        write i_row_wr_data into committed row i_row_wr_addr
//   i_row_wr_addr      row to write (>= HEIGHT is ignored)
//   i_row_wr_data      row contents, bit i = column i
//   i_start, i_steps   run request and generation count
//   o_busy             high in SCAN and COMMIT
//   o_done             one-cycle run-complete pulse
//   o_gen_count        generations committed since reset (wraps)
//   i_rd_addr          read row select
//   o_rd_data          committed row i_rd_addr, 0 when out of range
//   o_state            FSM state, for observation
module life_gen_sequencer #(
   parameter int WIDTH  = 8,
   parameter int HEIGHT = 8,
   parameter int ADDR_W = 3,
   parameter int STEP_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_row_wr_en,
   input  logic [ADDR_W-1:0] i_row_wr_addr,
   input  logic [WIDTH-1:0]  i_row_wr_data,
   input  logic              i_start,
   input  logic [STEP_W-1:0] i_steps,
   output logic              o_busy,
   output logic              o_done,
   output logic [CNT_W-1:0]  o_gen_count,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [WIDTH-1:0]  o_rd_data,
   output logic [1:0]        o_state
);

   localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SCAN   = 2'd1;
   localparam logic [1:0] S_COMMIT = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(HEIGHT - 1);
   localparam logic [COL_W-1:0]  LAST_COL = COL_W'(WIDTH - 1);

   logic [1:0]        r_state;
   logic [WIDTH-1:0]  r_grid   [HEIGHT];
   logic [WIDTH-1:0]  r_shadow [HEIGHT];
   logic [ADDR_W-1:0] r_row;
   logic [COL_W-1:0]  r_col;
   logic [STEP_W-1:0] r_remaining;
   logic [CNT_W-1:0]  r_gen_count;

   logic [WIDTH-1:0]  w_up;
   logic [WIDTH-1:0]  w_cur;
   logic [WIDTH-1:0]  w_dn;
   logic [WIDTH+1:0]  w_up_p;
   logic [WIDTH+1:0]  w_cur_p;
   logic [WIDTH+1:0]  w_dn_p;
   logic              w_lo_wrap;
   logic              w_hi_wrap;
   logic [3:0]        w_n;
   logic              w_alive;
   logic              w_next;
   logic              w_wr_ok;

   // Select the rows above, at and below the current cell from the
   // committed grid. Rows outside the grid stay zero unless wrapping.
   always_comb begin
      w_up  = '0;
      w_cur = '0;
      w_dn  = '0;
      for (int r = 0; r < HEIGHT; r++) begin
         if (r == int'(r_row))     w_cur = r_grid[r];
         if (r + 1 == int'(r_row)) w_up  = r_grid[r];
         if (r == int'(r_row) + 1) w_dn  = r_grid[r];
      end
`ifdef TOROIDAL_WRAP_EN
      if (r_row == '0)      w_up = r_grid[HEIGHT-1];
      if (r_row == LAST_ROW) w_dn = r_grid[0];
`endif
   end

`ifdef TOROIDAL_WRAP_EN
   assign w_lo_wrap = 1'b1;
   assign w_hi_wrap = 1'b1;
`else
   assign w_lo_wrap = 1'b0;
   assign w_hi_wrap = 1'b0;
`endif

   // Padded rows: bit 0 stands for column -1, bit WIDTH+1 for column WIDTH,
   // so the three neighbours of column c are bits c, c+1 and c+2.
   assign w_up_p  = {w_hi_wrap & w_up[0],  w_up,  w_lo_wrap & w_up[WIDTH-1]};
   assign w_cur_p = {w_hi_wrap & w_cur[0], w_cur, w_lo_wrap & w_cur[WIDTH-1]};
   assign w_dn_p  = {w_hi_wrap & w_dn[0],  w_dn,  w_lo_wrap & w_dn[WIDTH-1]};

   always_comb begin
      w_n     = '0;
      w_alive = 1'b0;
      for (int c = 0; c < WIDTH; c++) begin
         if (c == int'(r_col)) begin
            w_alive = w_cur_p[c+1];
            w_n = 4'(w_up_p[c]) + 4'(w_up_p[c+1]) + 4'(w_up_p[c+2])
                + 4'(w_cur_p[c])                   + 4'(w_cur_p[c+2])
                + 4'(w_dn_p[c]) + 4'(w_dn_p[c+1]) + 4'(w_dn_p[c+2]);
         end
      end
   end

   assign w_next  = (w_n == 4'd3) | (w_alive & (w_n == 4'd2));
   assign w_wr_ok = i_row_wr_en & ((r_state == S_IDLE) | (r_state == S_DONE));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_row       <= '0;
         r_col       <= '0;
         r_remaining <= '0;
         r_gen_count <= '0;
         for (int r = 0; r < HEIGHT; r++) begin
            r_grid[r]   <= '0;
            r_shadow[r] <= '0;
         end
      end else begin
         // Host row write; a write coinciding with an accepted start lands at
         // the same edge, so the first scan cycle already sees it.
         if (w_wr_ok) begin
            for (int r = 0; r < HEIGHT; r++) begin
               if (r == int'(i_row_wr_addr)) r_grid[r] <= i_row_wr_data;
            end
         end

         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  if (i_steps != '0) begin
                     r_state     <= S_SCAN;
                     r_remaining <= i_steps;
                     r_row       <= '0;
                     r_col       <= '0;
                  end else begin
                     r_state <= S_DONE;
                  end
               end
            end

            S_SCAN: begin
               for (int r = 0; r < HEIGHT; r++) begin
                  for (int c = 0; c < WIDTH; c++) begin
                     if (r == int'(r_row) && c == int'(r_col)) r_shadow[r][c] <= w_next;
                  end
               end
               if (r_col == LAST_COL) begin
                  r_col <= '0;
                  if (r_row == LAST_ROW) begin
                     r_row   <= '0;
                     r_state <= S_COMMIT;
                  end else begin
                     r_row <= r_row + 1'b1;
                  end
               end else begin
                  r_col <= r_col + 1'b1;
               end
            end

            S_COMMIT: begin
               for (int r = 0; r < HEIGHT; r++) r_grid[r] <= r_shadow[r];
               r_gen_count <= r_gen_count + 1'b1;
               r_remaining <= r_remaining - 1'b1;
               if (r_remaining == STEP_W'(1)) r_state <= S_DONE;
               else                           r_state <= S_SCAN;
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      o_rd_data = '0;
      for (int r = 0; r < HEIGHT; r++) begin
         if (r == int'(i_rd_addr)) o_rd_data = r_grid[r];
      end
   end

   assign o_busy      = (r_state == S_SCAN) | (r_state == S_COMMIT);
   assign o_done      = (r_state == S_DONE);
   assign o_gen_count = r_gen_count;
   assign o_state     = r_state;

endmodule
